// File: rtl/br_pkg.sv
// Shared constants and word type for the br_regfile register bank.
package br_pkg;

    localparam int BR_DATA_W = 8;
    localparam int BR_ADDR_W = 2;

    typedef logic [BR_DATA_W-1:0] br_word_t;

endpackage

// File: rtl/br_regfile_if.sv
// Access port of the register bank: shared address, write data, controls and read data.
interface br_regfile_if
    import br_pkg::*;
#(
    parameter int DATA_W = BR_DATA_W,
    parameter int ADDR_W = BR_ADDR_W
);
    logic [ADDR_W-1:0] Dir;
    logic [DATA_W-1:0] Dato_e;
    logic              WE;
    logic              En;
    logic [DATA_W-1:0] Dato_s;

    modport master (output Dir, Dato_e, WE, En, input Dato_s);
    modport slave  (input Dir, Dato_e, WE, En, output Dato_s);
endinterface

// File: rtl/br_word.sv
// One storage word: synchronous active-low clear with priority over the load enable.
module br_word
    import br_pkg::*;
#(
    parameter int DATA_W = BR_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/br_regfile.sv
// General-purpose register bank, DEPTH = 2**ADDR_W words. Define BR_OUT_REG_EN
// to register Dato_s (read latency 1); otherwise the read is combinational.
module br_regfile
    import br_pkg::*;
#(
    parameter int DATA_W = BR_DATA_W,
    parameter int ADDR_W = BR_ADDR_W
) (
    input  logic        clk,
    input  logic        rst_n,
    br_regfile_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] words [DEPTH];
    logic [DATA_W-1:0] rd_data;
    logic              wr_sel;
    logic              rd_sel;

    assign wr_sel = bus.En & bus.WE;
    assign rd_sel = bus.En & ~bus.WE;

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        br_word #(.DATA_W(DATA_W)) u_word (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (wr_sel && (bus.Dir == ADDR_W'(i))),
            .d     (bus.Dato_e),
            .q     (words[i])
        );
    end

    // Output is forced to zero whenever the bank is not being read.
    always_comb begin
        rd_data = '0;
        if (rd_sel) begin
            rd_data = words[bus.Dir];
        end
    end

`ifdef BR_OUT_REG_EN
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_data;
        end
    end

    assign bus.Dato_s = rd_q;
`else
    assign bus.Dato_s = rd_data;
`endif

endmodule

// File: tb/tb_br_regfile.sv
// Scoreboard bench for br_regfile: directed test-plan sequences plus random traffic.
module tb_br_regfile;
    import br_pkg::*;

`ifdef BR_OUT_REG_EN
    localparam bit REG_OUT = 1'b1;
`else
    localparam bit REG_OUT = 1'b0;
`endif

    typedef struct {
        logic [7:0] val;
        int         tag;
    } exp_t;

    logic clk;
    logic rst_n;
    br_regfile_if #(.DATA_W(8), .ADDR_W(2)) bus ();

    br_regfile #(.DATA_W(8), .ADDR_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    int         tag_cnt = 0;
    logic [7:0] mem [4];
    logic [7:0] prev_rd = 8'h00;

    // Monitor: every cycle that has an expectation queued, compare at the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if (bus.Dato_s !== e.val) begin
                errors++;
                $display("FAIL dato_s#%0d: got %0d, expected %0d", e.tag, bus.Dato_s, e.val);
            end
        end
    end

    // One bus cycle: drive inputs just after the edge, queue the expected output
    // for this cycle, then advance the reference model to the next edge.
    task automatic cyc(input logic r, input logic en, input logic we,
                       input logic [1:0] dir, input logic [7:0] d, input bit chk);
        logic [7:0] rd_now;
        exp_t e;
        @(posedge clk);
        #1;
        rst_n      = r;
        bus.En     = en;
        bus.WE     = we;
        bus.Dir    = dir;
        bus.Dato_e = d;
        rd_now = (en && !we) ? mem[dir] : 8'h00;
        if (chk) begin
            e.val = REG_OUT ? prev_rd : rd_now;
            e.tag = tag_cnt++;
            sb_q.push_back(e);
        end
        if (!r) begin
            for (int i = 0; i < 4; i++) mem[i] = 8'h00;
        end else if (en && we) begin
            mem[dir] = d;
        end
        prev_rd = r ? rd_now : 8'h00;
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.En     = 1'b0;
        bus.WE     = 1'b0;
        bus.Dir    = 2'd0;
        bus.Dato_e = 8'h00;

        // Reset held for two edges; outputs not yet defined in the registered build.
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
        for (int a = 0; a < 4; a++) cyc(1'b1, 1'b1, 1'b0, 2'(a), 8'h00, 1'b1);

        // Fill and read back.
        for (int a = 0; a < 4; a++) cyc(1'b1, 1'b1, 1'b1, 2'(a), 8'(10 * (a + 1)), 1'b1);
        for (int a = 0; a < 4; a++) cyc(1'b1, 1'b1, 1'b0, 2'(a), 8'h00, 1'b1);

        // Disabled write is ignored.
        cyc(1'b1, 1'b0, 1'b1, 2'd2, 8'd99, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 2'd2, 8'h00, 1'b1);

        // Overwrite one word, neighbours keep their values; includes write-then-read same address.
        cyc(1'b1, 1'b1, 1'b1, 2'd1, 8'hFF, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 2'd1, 8'h00, 1'b1);
        for (int a = 0; a < 4; a++) cyc(1'b1, 1'b1, 1'b0, 2'(a), 8'h00, 1'b1);

        // Reset wins over a simultaneous write.
        cyc(1'b0, 1'b1, 1'b1, 2'd3, 8'd77, 1'b1);
        for (int a = 3; a >= 0; a--) cyc(1'b1, 1'b1, 1'b0, 2'(a), 8'h00, 1'b1);

        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            logic r;
            r = ($urandom_range(0, 49) != 0);
            cyc(r, 1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom), 8'($urandom), 1'b1);
        end

        cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1);

        for (int w = 0; w < 20 && sb_q.size() > 0; w++) @(posedge clk);
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
        end
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
